sseg_scan_ctrl: RTL and testbench

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

---
 rtl/sseg_pkg.sv | 27 ++
 rtl/sseg_bin2bcd.sv | 72 +++++++
 rtl/sseg_scan_ctrl.sv | 90 +++++++++
 tb/tb_sseg_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Holds the display geometry and the single shift-add-3 step used by the converter.
package sseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 13;
    localparam int BCD_W      = 16;
    localparam int DIGIT_W    = 4;

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_t;

    // One double-dabble iteration: correct every nibble >= 5, then shift the next binary bit in.
    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] bcd,
                                                  input logic             bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*DIGIT_W +: DIGIT_W] >= 4'd5)
                adj[i*DIGIT_W +: DIGIT_W] = bcd[i*DIGIT_W +: DIGIT_W] + 4'd3;
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/sseg_bin2bcd.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per clock, VALUE_W steps per conversion.
// bcd is the combinational result of the final step and is only meaningful while done is high.
module sseg_bin2bcd
    import sseg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    localparam logic [3:0] LAST_ITER = 4'(VALUE_W - 1);

    conv_state_t        state;
    conv_state_t        state_nxt;
    logic [VALUE_W-1:0] shift_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_nxt;
    logic [3:0]         iter_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= CONV_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: each combinational output is given a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE: if (start)               state_nxt = CONV_RUN;
            CONV_RUN:  if (iter_q == LAST_ITER) state_nxt = CONV_IDLE;
            default:                            state_nxt = CONV_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (state == CONV_RUN) begin
            busy = 1'b1;
            done = (iter_q == LAST_ITER);
        end
    end

    assign bcd_nxt = bcd_step(bcd_q, shift_q[VALUE_W-1]);
    assign bcd     = bcd_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
        end else if (state == CONV_IDLE) begin
            if (start) begin
                shift_q <= value;
                bcd_q   <= '0;
                iter_q  <= '0;
            end
        end else begin
            shift_q <= shift_q << 1;
            bcd_q   <= bcd_nxt;
            iter_q  <= iter_q + 4'd1;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed display controller: BCD conversion on load, slot scanning,
// per-slot blanking window, PWM brightness and leading-zero suppression.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 25000,
    parameter int BLANK_CYC   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    output logic                  busy,
    input  logic [NUM_DIGITS-1:0] dp_en,
    input  logic                  blank_lead,
    input  logic [3:0]            brightness,
    output logic [NUM_DIGITS-1:0] an,
    output logic [DIGIT_W-1:0]    digit,
    output logic                  dp
);

    localparam int            PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

    logic [PW-1:0]         presc;
    logic [1:0]            sel;
    logic [BCD_W-1:0]      disp;
    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    logic [NUM_DIGITS-1:0] slot_blank;
    logic                  window;

    sseg_bin2bcd u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load & ~busy),
        .value (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            sel   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            sel   <= sel + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // NOTE: the display register is reset on purpose so a fresh part shows zeros, not garbage.
    always_ff @(posedge clk) begin
        if (rst)
            disp <= '0;
        else if (conv_done)
            disp <= conv_bcd;
    end

    // A slot is suppressed when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        logic lead_zero;
        slot_blank = '0;
        lead_zero  = blank_lead;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead_zero     = lead_zero && (disp[k*DIGIT_W +: DIGIT_W] == 4'd0);
            slot_blank[k] = lead_zero;
        end
    end

    assign window = (presc >= BLANK_END) && (presc[3:0] <= brightness);

    always_comb begin
        an    = '0;
        digit = '0;
        dp    = 1'b0;
        if (!rst) begin
            digit = disp[sel*DIGIT_W +: DIGIT_W];
            if (window && !slot_blank[sel]) begin
                an[sel] = 1'b1;
                dp      = dp_en[sel];
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: stimulus queues expected busy lengths and per-slot
// displays; a negedge monitor pops and compares them as the scan reaches each slot.
module tb_sseg_scan_ctrl;
    import sseg_pkg::*;

    localparam int DIV    = 32;
    localparam int BLANK  = 4;
    localparam int SAMPLE = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [12:0] value = '0;
    logic [3:0]  dp_en = '0;
    logic        blank_lead = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic        busy;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        dp;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .busy       (busy),
        .dp_en      (dp_en),
        .blank_lead (blank_lead),
        .brightness (brightness),
        .an         (an),
        .digit      (digit),
        .dp         (dp)
    );

    typedef struct {
        int       slot;
        logic [3:0] an;
        logic [3:0] digit;
        logic       dp;
    } slot_exp_t;

    slot_exp_t slot_q[$];
    int        busy_q[$];
    int        tests = 0;
    int        fails = 0;
    int        onehot_viol = 0;
    int        m_presc = 0;
    int        m_sel = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent model of the scan position, used only to know which slot is on screen.
    always @(posedge clk) begin
        if (rst) begin
            m_presc <= 0;
            m_sel   <= 0;
        end else if (m_presc == DIV - 1) begin
            m_presc <= 0;
            m_sel   <= (m_sel + 1) % 4;
        end else begin
            m_presc <= m_presc + 1;
        end
    end

    logic busy_prev = 1'b0;
    int   busy_len = 0;

    always @(negedge clk) begin
        if (!$onehot0(an)) onehot_viol++;
        if (busy === 1'b1) busy_len++;
        if (busy_prev && busy === 1'b0) begin
            if (busy_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL busy_unexpected: busy pulse of %0d cycles, expected none", busy_len);
            end else begin
                check("busy_len", busy_len, busy_q.pop_front());
            end
            busy_len = 0;
        end
        busy_prev = (busy === 1'b1);
        if (m_presc == SAMPLE && slot_q.size() > 0 && slot_q[0].slot == m_sel) begin
            slot_exp_t e;
            e = slot_q.pop_front();
            check($sformatf("slot%0d_an", e.slot), an, e.an);
            check($sformatf("slot%0d_digit", e.slot), digit, e.digit);
            check($sformatf("slot%0d_dp", e.slot), dp, e.dp);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [12:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy !== 1'b0; i++) step();
        check("busy_timeout", busy, 0);
    endtask

    task automatic push_slot(input int s, input logic [3:0] a, input logic [3:0] d, input logic p);
        slot_exp_t e;
        e.slot = s; e.an = a; e.digit = d; e.dp = p;
        slot_q.push_back(e);
    endtask

    // Expected slots given digit values d0..d3; bl marks blanked slots.
    task automatic push_all(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] d3, input logic [3:0] bl, input logic [3:0] dpe);
        push_slot(0, bl[0] ? 4'b0000 : 4'b0001, d0, bl[0] ? 1'b0 : dpe[0]);
        push_slot(1, bl[1] ? 4'b0000 : 4'b0010, d1, bl[1] ? 1'b0 : dpe[1]);
        push_slot(2, bl[2] ? 4'b0000 : 4'b0100, d2, bl[2] ? 1'b0 : dpe[2]);
        push_slot(3, bl[3] ? 4'b0000 : 4'b1000, d3, bl[3] ? 1'b0 : dpe[3]);
    endtask

    task automatic drain();
        for (int i = 0; i < 6 * DIV && (slot_q.size() > 0 || busy_q.size() > 0); i++) step();
        check("slot_q_drained", slot_q.size(), 0);
        check("busy_q_drained", busy_q.size(), 0);
    endtask

    task automatic align_slot();
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (m_presc == 0) break;
        end
    endtask

    initial begin
        int on_cnt;
        int early_cnt;
        int on_pos;
        logic [3:0] or_an;
        logic       or_dp;

        // Reset: outputs dark during reset and for the blank window that follows.
        dp_en = 4'hF;
        step(3);
        check("rst_an", an, 0);
        check("rst_digit", digit, 0);
        check("rst_dp", dp, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        or_an = '0;
        or_dp = 1'b0;
        for (int i = 0; i < BLANK; i++) begin
            @(negedge clk);
            or_an |= an;
            or_dp |= dp;
        end
        check("post_rst_blank_an", or_an, 0);
        check("post_rst_blank_dp", or_dp, 0);
        @(negedge clk);
        check("first_lit_an", an, 4'b0001);
        check("first_lit_digit", digit, 0);
        check("first_lit_dp", dp, 1);
        step();

        // 1234 -> slots 0..3 show 4,3,2,1.
        dp_en = 4'h0;
        busy_q.push_back(13);
        do_load(13'd1234);
        wait_idle();
        push_all(4'd4, 4'd3, 4'd2, 4'd1, 4'b0000, 4'b0000);
        drain();

        // Maximum value 8191.
        busy_q.push_back(13);
        do_load(13'd8191);
        wait_idle();
        push_all(4'd1, 4'd9, 4'd1, 4'd8, 4'b0000, 4'b0000);
        drain();

        // Zero with leading-zero suppression: only slot 0 may ever light.
        blank_lead = 1'b1;
        dp_en = 4'hF;
        busy_q.push_back(13);
        do_load(13'd0);
        wait_idle();
        push_all(4'd0, 4'd0, 4'd0, 4'd0, 4'b1110, 4'hF);
        or_an = '0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            or_an |= an;
        end
        check("zero_only_an0", or_an, 4'b0001);
        step();
        drain();

        // 42 with suppression and a dp on a blanked slot.
        dp_en = 4'b0100;
        busy_q.push_back(13);
        do_load(13'd42);
        wait_idle();
        push_all(4'd2, 4'd4, 4'd0, 4'd0, 4'b1100, 4'b0100);
        drain();

        // Brightness PWM with every slot visible.
        blank_lead = 1'b0;
        dp_en = 4'h0;
        for (int pass = 0; pass < 2; pass++) begin
            brightness = (pass == 0) ? 4'd15 : 4'd0;
            step();
            align_slot();
            on_cnt = 0;
            early_cnt = 0;
            on_pos = -1;
            for (int i = 0; i < DIV; i++) begin
                if (i > 0) @(negedge clk);
                if (an != 4'b0000) begin
                    on_cnt++;
                    on_pos = i;
                    if (i < BLANK) early_cnt++;
                end
            end
            check($sformatf("pwm%0d_on_cycles", pass), on_cnt, (pass == 0) ? 28 : 1);
            check($sformatf("pwm%0d_blank_window", pass), early_cnt, 0);
            check($sformatf("pwm%0d_last_on", pass), on_pos, (pass == 0) ? 31 : 16);
        end
        brightness = 4'd15;
        step();

        // A load during a conversion is dropped.
        busy_q.push_back(13);
        do_load(13'd777);
        step(4);
        value = 13'd555;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_idle();
        step(3);
        check("ignored_load_busy", busy, 0);
        push_all(4'd7, 4'd7, 4'd7, 4'd0, 4'b0000, 4'b0000);
        drain();

        // Reset at the 7th iteration aborts and clears the display.
        busy_q.push_back(7);
        do_load(13'd5678);
        step(6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        step(20);
        check("abort_busy_late", busy, 0);
        push_all(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'b0000);
        drain();

        // Reset wins over a simultaneous load.
        rst = 1'b1;
        value = 13'd100;
        load = 1'b1;
        step();
        rst = 1'b0;
        load = 1'b0;
        check("rst_over_load_busy", busy, 0);
        step(2);
        check("rst_over_load_busy_late", busy, 0);

        check("onehot0_violations", onehot_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
